// File: rtl/debug_scan_pkg.sv
// Shared types and widths for the debug scan master.
// State encoding, counter widths and default word sizes.
package debug_scan_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam int CW     = 6;
    localparam int DIVW   = 8;

    typedef enum logic [2:0] {
        IDLE,
        CAP,
        ADDR,
        DATA,
        RESP
    } state_t;

endpackage

// File: rtl/debug_scan_master_tick.sv
// drck divider: each bit slot is DIV cycles low followed by DIV cycles high.
// Held cleared while disabled so every scan opens on a fresh low half.
module scan_tick
    import debug_scan_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic drck,
    output logic fall_tick,
    output logic sample_tick
);

    logic [DIVW-1:0] cnt;
    logic            hlast;

    assign hlast = (cnt == DIVW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            drck <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            drck <= 1'b0;
        end else if (hlast) begin
            cnt  <= '0;
            drck <= ~drck;
        end else begin
            cnt <= cnt + DIVW'(1);
        end
    end

    // The edge closing a high half is both the tdo sample point
    // and the edge that opens the next low half (tdi update).
    assign sample_tick = en & drck & hlast;
    assign fall_tick   = en & drck & hlast;

endmodule

// File: rtl/debug_scan_master.sv
// Host-side scan initiator: serialises capture/address/data slots
// onto capture/shift/drck/tdi and collects tdo into a response word.
module debug_scan_master
    import debug_scan_pkg::*;
#(
    parameter int DIV = 2,
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    input  logic          cmd_dataonly,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          capture,
    output logic          shift,
    output logic          drck,
    output logic          tdi,
    input  logic          tdo
);

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [CW-1:0] bitcnt;
    logic          scan_en;
    logic          fall_tick;
    logic          sample_tick;

    assign scan_en = (state == CAP) || (state == ADDR) || (state == DATA);

    scan_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .en         (scan_en),
        .drck       (drck),
        .fall_tick  (fall_tick),
        .sample_tick(sample_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            capture   <= 1'b0;
            shift     <= 1'b0;
            tdi       <= 1'b0;
            bitcnt    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        bitcnt    <= '0;
                        addr_q    <= cmd_addr;
                        if (cmd_dataonly) begin
                            state   <= DATA;
                            shift   <= 1'b1;
                            tdi     <= cmd_data[DW-1];
                            data_q  <= {cmd_data[DW-2:0], 1'b0};
                        end else begin
                            state   <= CAP;
                            capture <= 1'b1;
                            tdi     <= 1'b0;
                            data_q  <= cmd_data;
                        end
                    end
                end
                CAP: begin
                    if (fall_tick) begin
                        state   <= ADDR;
                        capture <= 1'b0;
                        shift   <= 1'b1;
                        tdi     <= addr_q[AW-1];
                        addr_q  <= {addr_q[AW-2:0], 1'b0};
                    end
                end
                ADDR: begin
                    if (fall_tick) begin
                        if (bitcnt == CW'(AW - 1)) begin
                            state  <= DATA;
                            bitcnt <= '0;
                            tdi    <= data_q[DW-1];
                            data_q <= {data_q[DW-2:0], 1'b0};
                        end else begin
                            bitcnt <= bitcnt + CW'(1);
                            tdi    <= addr_q[AW-1];
                            addr_q <= {addr_q[AW-2:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        rsp_data <= {rsp_data[DW-2:0], tdo};
                    end
                    if (fall_tick) begin
                        if (bitcnt == CW'(DW - 1)) begin
                            state     <= RESP;
                            shift     <= 1'b0;
                            tdi       <= 1'b0;
                            rsp_valid <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + CW'(1);
                            tdi    <= data_q[DW-1];
                            data_q <= {data_q[DW-2:0], 1'b0};
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
